// File: rtl/snow64_bfloat16_vector_sequencer.sv
// Feeds a vector of BFloat16 lanes to a scalar FPU, one command per enabled lane.
// The scalar results are reassembled into a result vector, which is then presented with a one-cycle valid pulse.
module snow64_bfloat16_vector_sequencer #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 16,
  parameter int OPER_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_start,
  input  logic [OPER_WIDTH-1:0]           in_oper,
  input  logic [NUM_LANES-1:0]            in_lane_mask,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_b,
  output logic                            out_can_accept_cmd,
  output logic                            out_data_valid,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic                            out_fpu_start,
  output logic [OPER_WIDTH-1:0]           out_fpu_oper,
  output logic [LANE_WIDTH-1:0]           out_fpu_a,
  output logic [LANE_WIDTH-1:0]           out_fpu_b,
  input  logic                            in_fpu_can_accept_cmd,
  input  logic                            in_fpu_data_valid,
  input  logic [LANE_WIDTH-1:0]           in_fpu_data
);

  localparam int VEC_W = NUM_LANES * LANE_WIDTH;
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   lane_q, lane_d;
  logic [OPER_WIDTH-1:0] oper_q;
  logic [NUM_LANES-1:0]  mask_q;
  logic [VEC_W-1:0]   a_q, b_q;
  logic [VEC_W-1:0]   acc_q;
  logic [VEC_W-1:0]   data_q;
  logic               valid_q;

  int                 lane_base;
  logic               last_lane;
  logic               lane_en;

  assign lane_base = int'(lane_q) * LANE_WIDTH;
  assign last_lane = (lane_q == IDX_W'(NUM_LANES - 1));
  assign lane_en   = mask_q[lane_q];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d = S_ISSUE;
          lane_d  = '0;
        end
      end
      S_ISSUE: begin
        if (!lane_en) begin
          if (last_lane) state_d = S_DONE;
          else           lane_d  = lane_q + 1'b1;
        end else if (in_fpu_can_accept_cmd) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_fpu_data_valid) begin
          if (last_lane) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            lane_d  = lane_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. The FPU strobe depends only on registered state and FPU readiness, never on in_start.
  always_comb begin
    out_can_accept_cmd = (state_q == S_IDLE);
    out_fpu_start      = (state_q == S_ISSUE) && lane_en && in_fpu_can_accept_cmd;
    out_fpu_oper       = oper_q;
    out_fpu_a          = a_q[lane_base +: LANE_WIDTH];
    out_fpu_b          = b_q[lane_base +: LANE_WIDTH];
    out_data_valid     = valid_q;
    out_data           = data_q;
  end

  // Operand capture, per-lane accumulation and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oper_q  <= '0;
      mask_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == S_DONE);
      if (state_q == S_IDLE && in_start) begin
        oper_q <= in_oper;
        mask_q <= in_lane_mask;
        a_q    <= in_a;
        b_q    <= in_b;
      end
      if (state_q == S_ISSUE && !lane_en) begin
        acc_q[lane_base +: LANE_WIDTH] <= a_q[lane_base +: LANE_WIDTH];
      end
      if (state_q == S_WAIT && in_fpu_data_valid) begin
        acc_q[lane_base +: LANE_WIDTH] <= in_fpu_data;
      end
      // Partial results stay in acc_q; out_data only changes as the vector completes.
      if (state_q == S_DONE) begin
        data_q <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_snow64_bfloat16_vector_sequencer.sv
// Scoreboard bench: a driver pushes expected vectors and FPU commands, an FPU model answers commands,
// and a monitor pops and compares every result vector together with the cycle on which it arrives.
module tb_snow64_bfloat16_vector_sequencer;

  localparam int NL = 16;
  localparam int LW = 16;
  localparam int OW = 3;
  localparam int VW = NL * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_start;
  logic [OW-1:0] in_oper;
  logic [NL-1:0] in_lane_mask;
  logic [VW-1:0] in_a, in_b;
  logic          out_can_accept_cmd, out_data_valid;
  logic [VW-1:0] out_data;
  logic          out_fpu_start;
  logic [OW-1:0] out_fpu_oper;
  logic [LW-1:0] out_fpu_a, out_fpu_b;
  logic          in_fpu_can_accept_cmd, in_fpu_data_valid;
  logic [LW-1:0] in_fpu_data;

  snow64_bfloat16_vector_sequencer #(
    .NUM_LANES (NL),
    .LANE_WIDTH(LW),
    .OPER_WIDTH(OW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_start             (in_start),
    .in_oper              (in_oper),
    .in_lane_mask         (in_lane_mask),
    .in_a                 (in_a),
    .in_b                 (in_b),
    .out_can_accept_cmd   (out_can_accept_cmd),
    .out_data_valid       (out_data_valid),
    .out_data             (out_data),
    .out_fpu_start        (out_fpu_start),
    .out_fpu_oper         (out_fpu_oper),
    .out_fpu_a            (out_fpu_a),
    .out_fpu_b            (out_fpu_b),
    .in_fpu_can_accept_cmd(in_fpu_can_accept_cmd),
    .in_fpu_data_valid    (in_fpu_data_valid),
    .in_fpu_data          (in_fpu_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [VW-1:0] data;
    int            cyc;
  } job_t;

  typedef struct {
    logic [OW-1:0] op;
    logic [LW-1:0] a;
    logic [LW-1:0] b;
  } cmd_t;

  job_t          exp_q[$];
  cmd_t          cmd_q[$];
  logic [VW-1:0] last_out = '0;

  int            fpu_lat   = 1;
  int            fpu_stall = 0;
  int            fpu_cnt   = 0;
  int            stall_cnt = 0;
  bit            fpu_busy  = 1'b0;
  logic [LW-1:0] fpu_res   = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // BFloat16 reference arithmetic via doubles; only normal numbers are modelled exactly.
  function automatic real bf2r(input logic [15:0] x);
    logic [63:0] bits;
    if (x[14:7] == 8'd0) return 0.0;
    bits = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] bits;
    logic [10:0] e;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    e    = bits[62:52];
    if (e < 11'd897 || e > 11'd1150) return 16'h7FC0;
    return {bits[63], 8'(e - 11'd896), bits[51:45]};
  endfunction

  function automatic logic [15:0] fpu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0, 3'd5: return r2bf(bf2r(a) + bf2r(b));
      3'd1:       return r2bf(bf2r(a) - bf2r(b));
      3'd2:       return (bf2r(a) < bf2r(b)) ? 16'h3F80 : 16'h0000;
      3'd3:       return r2bf(bf2r(a) * bf2r(b));
      3'd4:       return (bf2r(b) == 0.0) ? 16'h7FC0 : r2bf(bf2r(a) / bf2r(b));
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic [VW-1:0] fill(input logic [LW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = 16'($urandom);
    return r;
  endfunction

  // FPU model: answers each command W cycles later, and holds off S cycles before accepting a command.
  initial begin
    cmd_t c;
    in_fpu_can_accept_cmd = 1'b0;
    in_fpu_data_valid     = 1'b0;
    in_fpu_data           = '0;
    forever begin
      @(negedge clk);
      in_fpu_data_valid = 1'b0;
      if (fpu_busy) begin
        in_fpu_can_accept_cmd = 1'b0;
        fpu_cnt--;
        if (fpu_cnt <= 0) begin
          in_fpu_data_valid = 1'b1;
          in_fpu_data       = fpu_res;
          fpu_busy          = 1'b0;
          stall_cnt         = fpu_stall;
        end
      end else if (stall_cnt > 0) begin
        stall_cnt--;
        in_fpu_can_accept_cmd = 1'b0;
      end else begin
        in_fpu_can_accept_cmd = 1'b1;
      end
      #1;
      if (out_fpu_start) begin
        check("start_only_when_ready", VW'(in_fpu_can_accept_cmd), VW'(1'b1));
        check("single_outstanding", VW'(fpu_busy), VW'(1'b0));
        if (cmd_q.size() == 0) begin
          check("unexpected_fpu_start", VW'(out_fpu_start), VW'(1'b0));
        end else begin
          c = cmd_q.pop_front();
          check("fpu_oper", VW'(out_fpu_oper), VW'(c.op));
          check("fpu_a", VW'(out_fpu_a), VW'(c.a));
          check("fpu_b", VW'(out_fpu_b), VW'(c.b));
        end
        fpu_busy = 1'b1;
        fpu_cnt  = fpu_lat;
        fpu_res  = fpu_ref(out_fpu_oper, out_fpu_a, out_fpu_b);
      end
    end
  end

  // Monitor: pops the scoreboard on every valid pulse; between pulses the output must hold.
  initial begin
    job_t j;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (out_data_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", VW'(out_data_valid), VW'(1'b0));
          end else begin
            j = exp_q.pop_front();
            check("out_data", out_data, j.data);
            check("valid_cycle", VW'(cyc), VW'(j.cyc));
            last_out = j.data;
          end
        end else begin
          check("out_data_hold", out_data, last_out);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !fpu_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait_timeout", VW'(ok), VW'(1'b1));
  endtask

  // Issues one vector request and records its expected result, latency and FPU command stream.
  task automatic issue_job(input logic [2:0] op, input logic [NL-1:0] mask, input logic [VW-1:0] a,
                           input logic [VW-1:0] b, input int w, input int s);
    job_t j;
    cmd_t c;
    int   lat;
    wait_idle();
    check("can_accept_before_start", VW'(out_can_accept_cmd), VW'(1'b1));
    fpu_lat      = w;
    fpu_stall    = s;
    stall_cnt    = s;
    in_oper      = op;
    in_lane_mask = mask;
    in_a         = a;
    in_b         = b;
    in_start     = 1'b1;
    lat          = 2;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        lat += 1 + w + s;
        c.op = op;
        c.a  = a[i*LW +: LW];
        c.b  = b[i*LW +: LW];
        cmd_q.push_back(c);
        j.data[i*LW +: LW] = fpu_ref(op, a[i*LW +: LW], b[i*LW +: LW]);
      end else begin
        lat += 1;
        j.data[i*LW +: LW] = a[i*LW +: LW];
      end
    end
    j.cyc = cyc + lat;
    exp_q.push_back(j);
    @(negedge clk);
    #2;
    in_start     = 1'b0;
    in_oper      = ~op;
    in_lane_mask = ~mask;
    in_a         = ~a;
    in_b         = ~b;
  endtask

  initial begin
    logic [VW-1:0] ramp;
    logic [VW-1:0] va, vb;
    bit            busy_ok;
    bit            reached;

    rst          = 1'b1;
    in_start     = 1'b0;
    in_oper      = '0;
    in_lane_mask = '0;
    in_a         = '0;
    in_b         = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_out_data", out_data, '0);
    check("reset_data_valid", VW'(out_data_valid), VW'(1'b0));
    check("reset_fpu_start", VW'(out_fpu_start), VW'(1'b0));
    check("reset_can_accept", VW'(out_can_accept_cmd), VW'(1'b1));
    #1;
    rst = 1'b0;

    // Add 1+2 on every lane, W=3: valid on cycle 66.
    issue_job(3'd0, 16'hFFFF, fill(16'h3F80), fill(16'h4000), 3, 0);
    // Sub 3-1 on every lane.
    issue_job(3'd1, 16'hFFFF, fill(16'h4040), fill(16'h3F80), 2, 0);
    // Mul 2*3 on lane 0 only; other lanes pass through a.
    va = fill(16'h1234);
    va[15:0] = 16'h4000;
    issue_job(3'd3, 16'h0001, va, fill(16'h4040), 1, 0);

    // All lanes disabled: ramp passes through, busy on cycles 1..17, valid on cycle 18.
    for (int i = 0; i < NL; i++) ramp[i*LW +: LW] = 16'(i);
    issue_job(3'd0, 16'h0000, ramp, rand_vec(), 1, 0);
    busy_ok = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (out_can_accept_cmd) busy_ok = 1'b0;
      @(negedge clk);
      #2;
    end
    check("busy_window_cycles_1_17", VW'(busy_ok), VW'(1'b1));
    check("idle_on_cycle_18", VW'(out_can_accept_cmd), VW'(1'b1));

    // Backpressure: 5 stall cycles before every command adds 80 cycles.
    issue_job(3'd0, 16'hFFFF, fill(16'h3F80), fill(16'h4000), 3, 5);

    // Random requests, including opcodes 6 and 7 and partial masks.
    for (int n = 0; n < 8; n++) begin
      issue_job(3'($urandom_range(0, 7)), 16'($urandom), rand_vec(), rand_vec(), $urandom_range(1, 4), 0);
    end

    // Reset while lane 7 is outstanding, then a stale FPU response.
    issue_job(3'd0, 16'hFFFF, fill(16'h3F80), fill(16'h4000), 3, 0);
    reached = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #2;
      if (cmd_q.size() <= 8) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_lane7", VW'(reached), VW'(1'b1));
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    cmd_q.delete();
    last_out  = '0;
    fpu_busy  = 1'b0;
    stall_cnt = 0;
    repeat (2) @(negedge clk);
    #3;
    check("midrun_reset_out_data", out_data, '0);
    check("midrun_reset_can_accept", VW'(out_can_accept_cmd), VW'(1'b1));
    rst      = 1'b0;
    fpu_res  = 16'hDEAD;
    fpu_cnt  = 2;
    fpu_busy = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    check("after_stale_out_data", out_data, '0);
    check("after_stale_can_accept", VW'(out_can_accept_cmd), VW'(1'b1));

    // A start request while busy is dropped and leaves the running result untouched.
    va = rand_vec();
    vb = rand_vec();
    issue_job(3'd3, 16'hFFFF, va, vb, 2, 0);
    repeat (3) @(negedge clk);
    #2;
    check("busy_can_accept_low", VW'(out_can_accept_cmd), VW'(1'b0));
    in_start     = 1'b1;
    in_oper      = 3'd0;
    in_lane_mask = 16'h00FF;
    in_a         = rand_vec();
    in_b         = rand_vec();
    @(negedge clk);
    #2;
    in_start = 1'b0;

    wait_idle();
    repeat (20) @(negedge clk);
    #2;
    check("no_leftover_fpu_cmds", VW'(cmd_q.size()), VW'(0));
    check("final_can_accept", VW'(out_can_accept_cmd), VW'(1'b1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
